// File: rtl/cerradura_digital.sv
// cerradura_digital: sequential code lock fed one 3-bit digit per `valido` strobe.
// Each digit is compared against the stored code digit at the current index.
// The result is only acted on once the last digit of the entry has been sampled.
//
// Build option CERRADURA_BLOQUEO_EN:
//   defined     -> after MAX_INT consecutive failed entries the lock goes into a
//                  timed lockout (BLOQUEO) in which every strobe is ignored.
//   not defined -> there is no lockout state. `bloqueado` is tied low and
//                  `intentos` saturates at 3.
//
// All outputs are registered, so none of them depends combinationally on A/valido.

module cerradura_digital #(
    parameter int                 N_DIG     = 4,
    parameter logic [3*N_DIG-1:0] CODIGO    = 12'b110_000_101_011,
    parameter int                 MAX_INT   = 3,
    parameter int                 T_ABIERTO = 8,
    parameter int                 T_BLOQUEO = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] A,
    input  logic       valido,
    output logic       F,
    output logic       error,
    output logic       bloqueado,
    output logic [1:0] intentos
);

    // Digit index width. N_DIG is at least 2, so this is always at least 1 bit.
    localparam int IW = $clog2(N_DIG);

    // One timer is shared by the open window and the lockout window.
    // It is sized for the longer of the two. It counts down from T-1, so
    // $clog2(T) bits are enough.
    localparam int T_MAX = (T_ABIERTO > T_BLOQUEO) ? T_ABIERTO : T_BLOQUEO;
    localparam int TW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;

    localparam logic [IW-1:0] ULTIMO_IDX    = IW'(N_DIG - 1);
    localparam logic [TW-1:0] CARGA_ABIERTO = TW'(T_ABIERTO - 1);
`ifdef CERRADURA_BLOQUEO_EN
    localparam logic [TW-1:0] CARGA_BLOQUEO = TW'(T_BLOQUEO - 1);
    localparam logic [1:0]    LIMITE_INT    = 2'(MAX_INT);
`endif

    // Without the lockout option the BLOQUEO encoding simply does not exist.
`ifdef CERRADURA_BLOQUEO_EN
    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        ABIERTO = 2'd1,
        BLOQUEO = 2'd2
    } estado_t;
`else
    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        ABIERTO = 2'd1
    } estado_t;
`endif

    estado_t       estado;
    logic [IW-1:0] indice;
    logic          coincide;
    logic [TW-1:0] temporizador;

    logic [2:0]    digitos [N_DIG];
    logic [2:0]    digito_codigo;
    logic          digito_ok;
    logic          coincide_sig;
    logic          es_ultimo;

    // Split the packed code into per-digit slices. Digit 0, the first one
    // entered, sits in the least significant bits.
    genvar g;
    generate
        for (g = 0; g < N_DIG; g++) begin : g_digitos
            assign digitos[g] = CODIGO[3*g +: 3];
        end
    endgenerate

    // Per-digit equality comparator. It also folds this digit's result into the running match flag.
    always_comb begin
        digito_codigo = digitos[indice];
        digito_ok     = (A == digito_codigo);
        coincide_sig  = coincide & digito_ok;
        es_ultimo     = (indice == ULTIMO_IDX);
    end

    // Main evaluation FSM. It also owns the attempt counter, the shared timer and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado       <= ESPERA;
            indice       <= '0;
            coincide     <= 1'b1;
            temporizador <= '0;
            intentos     <= 2'd0;
            F            <= 1'b0;
            error        <= 1'b0;
`ifdef CERRADURA_BLOQUEO_EN
            bloqueado    <= 1'b0;
`endif
        end else begin
            error <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (valido) begin
                        if (es_ultimo) begin
                            indice   <= '0;
                            coincide <= 1'b1;
                            if (coincide_sig) begin
                                estado       <= ABIERTO;
                                F            <= 1'b1;
                                intentos     <= 2'd0;
                                temporizador <= CARGA_ABIERTO;
                            end else begin
                                error <= 1'b1;
`ifdef CERRADURA_BLOQUEO_EN
                                intentos <= intentos + 2'd1;
                                if ((intentos + 2'd1) == LIMITE_INT) begin
                                    estado       <= BLOQUEO;
                                    bloqueado    <= 1'b1;
                                    temporizador <= CARGA_BLOQUEO;
                                end
`else
                                if (intentos != 2'd3) begin
                                    intentos <= intentos + 2'd1;
                                end
`endif
                            end
                        end else begin
                            indice   <= indice + IW'(1);
                            coincide <= coincide_sig;
                        end
                    end
                end

                ABIERTO: begin
                    if (temporizador == '0) begin
                        estado   <= ESPERA;
                        F        <= 1'b0;
                        indice   <= '0;
                        coincide <= 1'b1;
                    end else begin
                        temporizador <= temporizador - TW'(1);
                    end
                end

`ifdef CERRADURA_BLOQUEO_EN
                BLOQUEO: begin
                    if (temporizador == '0) begin
                        estado    <= ESPERA;
                        bloqueado <= 1'b0;
                        intentos  <= 2'd0;
                        indice    <= '0;
                        coincide  <= 1'b1;
                    end else begin
                        temporizador <= temporizador - TW'(1);
                    end
                end
`endif

                default: begin
                    estado   <= ESPERA;
                    F        <= 1'b0;
                    indice   <= '0;
                    coincide <= 1'b1;
                end
            endcase
        end
    end

`ifndef CERRADURA_BLOQUEO_EN
    // Lockout is not built in this configuration, so the indicator stays low.
    assign bloqueado = 1'b0;
`endif

endmodule

// File: tb/tb_cerradura_digital.sv
// tb_cerradura_digital: directed and random stimulus for cerradura_digital.
// The bench compares the DUT against a reference model of the lock.
// The model works on whole entries and absolute cycle numbers, not on FSM states.
// It follows CERRADURA_BLOQUEO_EN exactly as the design does.

module tb_cerradura_digital;

    localparam int N_DIG     = 4;
    localparam int MAX_INT   = 3;
    localparam int T_ABIERTO = 8;
    localparam int T_BLOQUEO = 16;

    logic       clk;
    logic       rst;
    logic [2:0] A;
    logic       valido;
    logic       F;
    logic       error;
    logic       bloqueado;
    logic [1:0] intentos;

    int vectors;
    int miscompares;

    // Reference model state: digits typed in the current entry, the cycle
    // numbers at which the open/lockout windows end, and the failure count.
    int code_q [N_DIG] = '{3, 5, 0, 6};
    int entered [$];
    int edge_n;
    int open_end;
    int lock_end;
    int fails;
    bit exp_err;

    cerradura_digital #(
        .N_DIG     (N_DIG),
        .CODIGO    (12'b110_000_101_011),
        .MAX_INT   (MAX_INT),
        .T_ABIERTO (T_ABIERTO),
        .T_BLOQUEO (T_BLOQUEO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .valido    (valido),
        .F         (F),
        .error     (error),
        .bloqueado (bloqueado),
        .intentos  (intentos)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one rising edge that saw these inputs.
    task automatic modelStep(input bit r, input bit v, input logic [2:0] a);
        bit busy;
        bit ok;
        edge_n++;
        exp_err = 1'b0;
        if (r) begin
            entered.delete();
            fails    = 0;
            open_end = 0;
            lock_end = 0;
        end else begin
            if (lock_end != 0 && edge_n == lock_end) fails = 0;
            busy = ((edge_n - 1) < open_end) || ((edge_n - 1) < lock_end);
            if (v && !busy) begin
                entered.push_back(int'(a));
                if (entered.size() == N_DIG) begin
                    ok = 1'b1;
                    for (int i = 0; i < N_DIG; i++)
                        if (entered[i] != code_q[i]) ok = 1'b0;
                    entered.delete();
                    if (ok) begin
                        open_end = edge_n + T_ABIERTO;
                        fails    = 0;
                    end else begin
                        exp_err = 1'b1;
`ifdef CERRADURA_BLOQUEO_EN
                        fails++;
                        if (fails == MAX_INT) lock_end = edge_n + T_BLOQUEO;
`else
                        if (fails < 3) fails++;
`endif
                    end
                end
            end
        end
    endtask

    // Compare all four DUT outputs with the model after the current edge.
    task automatic checkOutput();
        logic       e_f;
        logic       e_b;
        logic [1:0] e_i;
        e_f = (edge_n < open_end);
        e_b = (edge_n < lock_end);
        e_i = 2'(fails);
        vectors++;
        assert (F === e_f) else begin
            miscompares++;
            $error("[TB] FAIL F @edge %0d: observed %b expected %b", edge_n, F, e_f);
        end
        vectors++;
        assert (error === exp_err) else begin
            miscompares++;
            $error("[TB] FAIL error @edge %0d: observed %b expected %b", edge_n, error, exp_err);
        end
        vectors++;
        assert (bloqueado === e_b) else begin
            miscompares++;
            $error("[TB] FAIL bloqueado @edge %0d: observed %b expected %b", edge_n, bloqueado, e_b);
        end
        vectors++;
        assert (intentos === e_i) else begin
            miscompares++;
            $error("[TB] FAIL intentos @edge %0d: observed %0d expected %0d", edge_n, intentos, e_i);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then check just after it.
    task automatic applyStimulus(input bit r, input bit v, input logic [2:0] a);
        rst    = r;
        valido = v;
        A      = a;
        @(posedge clk);
        modelStep(r, v, a);
        #1;
        checkOutput();
    endtask

    task automatic enterCode(input int d0, input int d1, input int d2, input int d3);
        applyStimulus(1'b0, 1'b1, 3'(d0));
        applyStimulus(1'b0, 1'b1, 3'(d1));
        applyStimulus(1'b0, 1'b1, 3'(d2));
        applyStimulus(1'b0, 1'b1, 3'(d3));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'($urandom_range(0, 7)));
    endtask

    // Directed scenarios first, then a randomized run against the same model.
    initial begin
        bit         r;
        bit         v;
        logic [2:0] a;
        vectors     = 0;
        miscompares = 0;
        edge_n      = 0;
        open_end    = 0;
        lock_end    = 0;
        fails       = 0;
        exp_err     = 1'b0;
        rst         = 1'b1;
        valido      = 1'b0;
        A           = 3'd0;

        // Reset values
        applyStimulus(1'b1, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b1, 3'd3);

        // Correct code opens for T_ABIERTO cycles
        enterCode(3, 5, 0, 6);
        idle(10);

        // Wrong third digit, then the correct code clears the attempt count
        enterCode(3, 5, 1, 6);
        idle(2);
        enterCode(3, 5, 0, 6);
        idle(2);

        // Digits strobed while open are dropped
        applyStimulus(1'b0, 1'b1, 3'd3);
        applyStimulus(1'b0, 1'b1, 3'd5);
        idle(6);
        enterCode(3, 5, 0, 6);
        idle(10);

        // Three wrong entries, correct code during a possible lockout, then after it
        enterCode(1, 1, 1, 1);
        enterCode(3, 5, 0, 7);
        idle(1);
        enterCode(0, 0, 0, 0);
        enterCode(3, 5, 0, 6);
        idle(20);
        enterCode(3, 5, 0, 6);
        idle(10);

        // Reset after two correct digits, then a fresh entry
        applyStimulus(1'b0, 1'b1, 3'd3);
        applyStimulus(1'b0, 1'b1, 3'd5);
        applyStimulus(1'b1, 1'b1, 3'd0);
        enterCode(3, 5, 0, 6);
        idle(10);

        // Reset on the last-digit edge takes priority
        applyStimulus(1'b0, 1'b1, 3'd3);
        applyStimulus(1'b0, 1'b1, 3'd5);
        applyStimulus(1'b0, 1'b1, 3'd0);
        applyStimulus(1'b1, 1'b1, 3'd6);
        idle(2);

        // Reset in the middle of a lockout (or after three failures)
        enterCode(7, 7, 7, 7);
        enterCode(7, 7, 7, 7);
        enterCode(7, 7, 7, 7);
        idle(5);
        applyStimulus(1'b1, 1'b0, 3'd0);
        enterCode(3, 5, 0, 6);
        idle(10);

        // Four back-to-back wrong entries
        enterCode(2, 2, 2, 2);
        enterCode(3, 5, 0, 5);
        enterCode(6, 0, 5, 3);
        enterCode(3, 3, 3, 3);
        idle(20);

        // Randomized traffic biased toward the correct next digit
        for (int k = 0; k < 500; k++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0 && entered.size() < N_DIG)
                a = 3'(code_q[entered.size()]);
            else
                a = 3'($urandom_range(0, 7));
            applyStimulus(r, v, a);
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cerradura_digital.md
# cerradura_digital

Sequential code lock that accepts 3-bit digits one per strobe, compares each against a stored code digit by 3-bit equality, and opens after a full correct sequence. It sits directly downstream of the 3-bit equality comparator: the comparator's per-digit match result feeds this block's evaluation FSM, attempt counter and lockout timer. Outputs drive the lock actuator (`F`) and status indicators.

## Interface
- `N_DIG`, 4, digits per code (2..8)
- `CODIGO`, 12'b110_000_101_011, stored code; digit i at bits [3i+2:3i]; digit 0 entered first (default sequence 3,5,0,6)
- `MAX_INT`, 3, failed attempts before lockout (1..3)
- `T_ABIERTO`, 8, cycles `F` stays high
- `T_BLOQUEO`, 16, lockout duration in cycles

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `A`  in  3  entered digit, sampled only when `valido`=1
- `valido`  in  1  digit strobe, one sample per high cycle
- `F`  out  1  lock open
- `error`  out  1  one-cycle pulse on a failed complete entry
- `bloqueado`  out  1  lockout active
- `intentos`  out  2  consecutive failed attempts

## Operation
- States: ESPERA, ABIERTO, BLOQUEO. Reset -> ESPERA, digit index 0, match flag 1, `intentos`=0, `F`=0, `error`=0, `bloqueado`=0, timers 0.
- ESPERA, `valido`=1: match flag &= (`A` == digit[index]); index++.
- Match flag and index are not evaluated until digit N_DIG-1 is sampled; a wrong early digit does not abort the entry.
- Last digit sampled (index==N_DIG-1), using the match including this digit:
  - all matched -> ABIERTO, `intentos`=0, timer loads T_ABIERTO-1.
  - otherwise -> `error` pulses; `intentos`++. If new `intentos`==MAX_INT -> BLOQUEO, timer loads T_BLOQUEO-1; else stay in ESPERA.
  - In every case, index returns to 0 and match flag to 1.
- ABIERTO:
  - `F`=1; timer decrements each cycle; at 0 -> ESPERA.
  - `valido` ignored; digits are not buffered.
- BLOQUEO:
  - `bloqueado`=1; `valido` ignored; timer decrements each cycle.
  - At 0 -> ESPERA with `intentos`=0.
- Index and match flag reset on each state exit, so every entry starts clean.
- `valido` held high for k cycles = k digits.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Last digit sampled on edge E: `F`/`error`/`bloqueado`/`intentos` update at E. `error` high for exactly one cycle after E.
- `F` high for exactly T_ABIERTO cycles; first `valido` accepted on the edge after `F` falls.
- `bloqueado` high for exactly T_BLOQUEO cycles.
- `rst` has priority over every event, including a last-digit strobe on the same edge. Mid-entry, mid-open or mid-lockout, reset returns to reset values on that edge.

## Configuration
- `CERRADURA_BLOQUEO_EN` defined: lockout as above.
- Not defined:
  - BLOQUEO state and its timer are not built; `bloqueado` is tied to 0.
  - A failed entry pulses `error` and stays in ESPERA.
  - `intentos` saturates at 3.
  - `MAX_INT` and `T_BLOQUEO` are unused.

## Test plan
- Reset, then `valido` with A=3,5,0,6 on consecutive cycles -> `F`=1 for 8 cycles starting after the 4th edge, `intentos`=0, `error` never high.
- Entry 3,5,1,6 -> single-cycle `error`, `intentos`=1, `F`=0. A following 3,5,0,6 then opens and clears `intentos` to 0.
- Three wrong entries (macro on) -> `intentos`=3 and `bloqueado`=1 for 16 cycles. Correct code strobed during lockout is ignored. After lockout, `intentos`=0 and the correct code opens.
- `valido` pulses with A=3,5 while `F`=1 -> ignored. A subsequent full 3,5,0,6 after `F` falls opens again.
- `rst` asserted after 2 correct digits, and again mid-lockout -> all outputs 0 next cycle. A fresh 3,5,0,6 opens.
- Macro off: four wrong entries -> four `error` pulses, `intentos` 1,2,3,3, `bloqueado` always 0.
